decode_fwd_stage: RTL and testbench

//   Y86-64 decode stage with registered D->E pipeline register, parametrised in data and register-id width.
//   Per icode: selects srcA/srcB/dstE/dstM. Forwards valA/valB from E/M/W over register-file data.

---
 rtl/y86_pkg.sv | 44 ++++
 rtl/fwd_select.sv | 66 ++++++
 rtl/decode_fwd_stage.sv | 194 +++++++++++++++++++
 tb/tb_decode_fwd_stage.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg
//   Shared Y86-64 encodings for the pipeline: instruction codes, the stack
//   pointer register id, the default "no register" id and status codes.
//   Helper functions classify icodes where more than one stage needs the
//   same decision.
package y86_pkg;

  // Instruction codes (upper nibble of the first instruction byte).
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovXX
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Register ids. RNONE is all-ones at whatever register-id width a stage
  // uses; this constant is the 4-bit form.
  localparam int         RSP       = 4;
  localparam logic [3:0] RNONE_DEF = 4'hF;

  // Status codes. Kept as integers so each stage can size them to its own
  // status width; S_INS needs at least three bits to survive unchanged.
  localparam int S_AOK = 1;
  localparam int S_HLT = 2;
  localparam int S_ADR = 3;
  localparam int S_INS = 4;

  // call and jXX carry the fall-through PC down the pipe in valA.
  function automatic logic uses_valp(input logic [3:0] icode);
    return (icode == I_CALL) || (icode == I_JXX);
  endfunction

  // Instructions whose result only exists after the memory stage.
  function automatic logic is_load(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// fwd_select
//   Operand select for one decode source: a priority mux over the five
//   in-flight results (execute, memory load, memory ALU, write-back load,
//   write-back ALU) with register-file data as the fallback. When USE_VALP
//   is set, a call/jXX instruction takes the fall-through PC ahead of
//   every forward.
// Ports
//   sel_valp  in  1       current instruction passes valP down as valA
//   val_p     in  DATA_W  fall-through PC
//   src       in  RID_W   source register id being read
//   e_dst_e, e_val_e   in  execute-stage ALU result
//   m_dst_m, m_val_m   in  memory-stage load result
//   m_dst_e, m_val_e   in  memory-stage ALU result
//   w_dst_m, w_val_m   in  write-back load result
//   w_dst_e, w_val_e   in  write-back ALU result
//   rf_val    in  DATA_W  register-file read data for src
//   val_out   out DATA_W  selected operand
module fwd_select #(
  parameter int DATA_W   = 64,
  parameter int RID_W    = 4,
  parameter bit USE_VALP = 1'b0
) (
  input  logic              sel_valp,
  input  logic [DATA_W-1:0] val_p,
  input  logic [RID_W-1:0]  src,
  input  logic [RID_W-1:0]  e_dst_e,
  input  logic [DATA_W-1:0] e_val_e,
  input  logic [RID_W-1:0]  m_dst_m,
  input  logic [DATA_W-1:0] m_val_m,
  input  logic [RID_W-1:0]  m_dst_e,
  input  logic [DATA_W-1:0] m_val_e,
  input  logic [RID_W-1:0]  w_dst_m,
  input  logic [DATA_W-1:0] w_val_m,
  input  logic [RID_W-1:0]  w_dst_e,
  input  logic [DATA_W-1:0] w_val_e,
  input  logic [DATA_W-1:0] rf_val,
  output logic [DATA_W-1:0] val_out
);

  localparam logic [RID_W-1:0] RNONE = '1;

  // Stages with no destination report RNONE, so an RNONE source would
  // otherwise match them; it must always fall through to the file.
  logic src_live;
  assign src_live = (src != RNONE);

  // The youngest producer wins: execute before memory before write-back,
  // and within a stage the load result before the ALU result.
  always_comb begin
    val_out = rf_val;
    if (USE_VALP && sel_valp) begin
      val_out = val_p;
    end else if (src_live && (src == e_dst_e)) begin
      val_out = e_val_e;
    end else if (src_live && (src == m_dst_m)) begin
      val_out = m_val_m;
    end else if (src_live && (src == m_dst_e)) begin
      val_out = m_val_e;
    end else if (src_live && (src == w_dst_m)) begin
      val_out = w_val_m;
    end else if (src_live && (src == w_dst_e)) begin
      val_out = w_val_e;
    end
  end

endmodule

// File: rtl/decode_fwd_stage.sv
// decode_fwd_stage
//   Y86-64 decode stage plus the D->E pipeline register. Picks source and
//   destination register ids from the icode, forwards valA/valB from the
//   execute, memory and write-back stages, and flags a load-use hazard when
//   the instruction sitting in E is a load whose destination decode needs.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   D_stat/icode/ifun/rA/rB    fields from the fetch D register
//   D_valC, D_valP             constant word and fall-through PC
//   rf_valA, rf_valB           register-file data for d_srcA / d_srcB
//   e_dstE/e_valE ... W_valE   forward sources from later stages
//   E_stall, E_bubble          E register hold / nop insertion
//   d_srcA, d_srcB             combinational register-file read addresses
//   load_use                   combinational hazard flag
//   E_*                        registered decode results for execute
module decode_fwd_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int RID_W  = 4,
  parameter int STAT_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STAT_W-1:0] D_stat,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [RID_W-1:0]  D_rA,
  input  logic [RID_W-1:0]  D_rB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic [DATA_W-1:0] rf_valA,
  input  logic [DATA_W-1:0] rf_valB,
  input  logic [RID_W-1:0]  e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [RID_W-1:0]  M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [RID_W-1:0]  M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [RID_W-1:0]  W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [RID_W-1:0]  W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic              E_stall,
  input  logic              E_bubble,
  output logic [RID_W-1:0]  d_srcA,
  output logic [RID_W-1:0]  d_srcB,
  output logic              load_use,
  output logic [STAT_W-1:0] E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [RID_W-1:0]  E_dstE,
  output logic [RID_W-1:0]  E_dstM,
  output logic [RID_W-1:0]  E_srcA,
  output logic [RID_W-1:0]  E_srcB
);

  localparam logic [RID_W-1:0]  RNONE    = '1;
  localparam logic [RID_W-1:0]  RSP_ID   = RID_W'(RSP);
  localparam logic [STAT_W-1:0] STAT_AOK = STAT_W'(S_AOK);

  logic [RID_W-1:0]  d_dstE;
  logic [RID_W-1:0]  d_dstM;
  logic [DATA_W-1:0] d_valA;
  logic [DATA_W-1:0] d_valB;
  logic              valp_sel;

  assign valp_sel = uses_valp(D_icode);

  // Register selection by instruction class. Stack operations implicitly
  // read and/or write %rsp; anything not listed uses no register.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;

    case (D_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = D_rA;
      I_POPQ, I_RET:                     d_srcA = RSP_ID;
      default: ;
    endcase

    case (D_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcB = D_rB;
      I_PUSHQ, I_POPQ, I_CALL, I_RET:     d_srcB = RSP_ID;
      default: ;
    endcase

    case (D_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          d_dstE = D_rB;
      I_PUSHQ, I_POPQ, I_CALL, I_RET:     d_dstE = RSP_ID;
      default: ;
    endcase

    case (D_icode)
      I_MRMOVQ, I_POPQ:                   d_dstM = D_rA;
      default: ;
    endcase
  end

  fwd_select #(
    .DATA_W  (DATA_W),
    .RID_W   (RID_W),
    .USE_VALP(1'b1)
  ) u_fwd_a (
    .sel_valp(valp_sel),
    .val_p   (D_valP),
    .src     (d_srcA),
    .e_dst_e (e_dstE),
    .e_val_e (e_valE),
    .m_dst_m (M_dstM),
    .m_val_m (m_valM),
    .m_dst_e (M_dstE),
    .m_val_e (M_valE),
    .w_dst_m (W_dstM),
    .w_val_m (W_valM),
    .w_dst_e (W_dstE),
    .w_val_e (W_valE),
    .rf_val  (rf_valA),
    .val_out (d_valA)
  );

  // valB never carries valP; the select input is tied off.
  fwd_select #(
    .DATA_W  (DATA_W),
    .RID_W   (RID_W),
    .USE_VALP(1'b0)
  ) u_fwd_b (
    .sel_valp(1'b0),
    .val_p   (D_valP),
    .src     (d_srcB),
    .e_dst_e (e_dstE),
    .e_val_e (e_valE),
    .m_dst_m (M_dstM),
    .m_val_m (m_valM),
    .m_dst_e (M_dstE),
    .m_val_e (M_valE),
    .w_dst_m (W_dstM),
    .w_val_m (W_valM),
    .w_dst_e (W_dstE),
    .w_val_e (W_valE),
    .rf_val  (rf_valB),
    .val_out (d_valB)
  );

  // A load in E has not produced its data yet, so no forward can cover a
  // decode read of its destination. Only E's own fields feed this; the
  // pipeline controller decides what to do with it.
  assign load_use = is_load(E_icode) && (E_dstM != RNONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));

  // Bubble beats stall so a squash is never lost while execute is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      E_stat  <= STAT_AOK;
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else if (E_bubble) begin
      E_stat  <= STAT_AOK;
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else if (!E_stall) begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

endmodule

// File: tb/tb_decode_fwd_stage.sv
// tb_decode_fwd_stage
//   Self-checking bench for decode_fwd_stage: a default 64/4 instance
//   checked against a behavioural model of the decode tables and forward
//   priority, plus a 32/5 instance for the width cases.
module tb_decode_fwd_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default-width instance signals.
  logic [1:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP, rf_valA, rf_valB;
  logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic        E_stall, E_bubble;
  logic [3:0]  d_srcA, d_srcB;
  logic        load_use;
  logic [1:0]  E_stat;
  logic [3:0]  E_icode, E_ifun;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

  // 32-bit data / 5-bit register id instance signals.
  logic [1:0]  w_D_stat;
  logic [3:0]  w_D_icode, w_D_ifun;
  logic [4:0]  w_D_rA, w_D_rB;
  logic [31:0] w_D_valC, w_D_valP, w_rf_valA, w_rf_valB;
  logic [4:0]  w_e_dstE, w_M_dstM, w_M_dstE, w_W_dstM, w_W_dstE;
  logic [31:0] w_e_valE, w_m_valM, w_M_valE, w_W_valM, w_W_valE;
  logic        w_E_stall, w_E_bubble;
  logic [4:0]  w_d_srcA, w_d_srcB;
  logic        w_load_use;
  logic [1:0]  w_E_stat;
  logic [3:0]  w_E_icode, w_E_ifun;
  logic [31:0] w_E_valC, w_E_valA, w_E_valB;
  logic [4:0]  w_E_dstE, w_E_dstM, w_E_srcA, w_E_srcB;

  decode_fwd_stage dut (
    .clk(clk), .rst_n(rst_n), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
    .rf_valA(rf_valA), .rf_valB(rf_valB), .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .M_dstE(M_dstE), .M_valE(M_valE),
    .W_dstM(W_dstM), .W_valM(W_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .E_stall(E_stall), .E_bubble(E_bubble), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .load_use(load_use), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE),
    .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  decode_fwd_stage #(.DATA_W(32), .RID_W(5), .STAT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .D_stat(w_D_stat), .D_icode(w_D_icode), .D_ifun(w_D_ifun),
    .D_rA(w_D_rA), .D_rB(w_D_rB), .D_valC(w_D_valC), .D_valP(w_D_valP),
    .rf_valA(w_rf_valA), .rf_valB(w_rf_valB), .e_dstE(w_e_dstE), .e_valE(w_e_valE),
    .M_dstM(w_M_dstM), .m_valM(w_m_valM), .M_dstE(w_M_dstE), .M_valE(w_M_valE),
    .W_dstM(w_W_dstM), .W_valM(w_W_valM), .W_dstE(w_W_dstE), .W_valE(w_W_valE),
    .E_stall(w_E_stall), .E_bubble(w_E_bubble), .d_srcA(w_d_srcA), .d_srcB(w_d_srcB),
    .load_use(w_load_use), .E_stat(w_E_stat), .E_icode(w_E_icode), .E_ifun(w_E_ifun),
    .E_valC(w_E_valC), .E_valA(w_E_valA), .E_valB(w_E_valB), .E_dstE(w_E_dstE),
    .E_dstM(w_E_dstM), .E_srcA(w_E_srcA), .E_srcB(w_E_srcB)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } e_t;

  e_t exp_e;

  function automatic e_t bubble_e();
    e_t b;
    b.stat = 2'd1; b.icode = 4'd1; b.ifun = 4'd0;
    b.valC = '0; b.valA = '0; b.valB = '0;
    b.dstE = 4'hF; b.dstM = 4'hF; b.srcA = 4'hF; b.srcB = 4'hF;
    return b;
  endfunction

  function automatic e_t dut_e();
    return {E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB};
  endfunction

  function automatic logic [3:0] src_a_of(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] src_b_of(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] dst_e_of(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] dst_m_of(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  // First producer (youngest first) whose destination names src.
  function automatic logic [63:0] fwd_of(input logic [3:0] src, input logic [63:0] rf);
    logic [3:0]  dsts [5];
    logic [63:0] vals [5];
    dsts = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (src == 4'hF) return rf;
    for (int k = 0; k < 5; k++)
      if (dsts[k] == src) return vals[k];
    return rf;
  endfunction

  function automatic logic exp_load_use();
    logic [3:0] sa, sb;
    sa = src_a_of(D_icode, D_rA);
    sb = src_b_of(D_icode, D_rB);
    return (exp_e.icode == 4'h5 || exp_e.icode == 4'hB) && exp_e.dstM != 4'hF &&
           (exp_e.dstM == sa || exp_e.dstM == sb);
  endfunction

  // Computes what E should hold after the coming edge, waits for it,
  // and settles just past the edge.
  task automatic tick();
    e_t nx;
    if (!rst_n || E_bubble) begin
      nx = bubble_e();
    end else if (E_stall) begin
      nx = exp_e;
    end else begin
      nx.stat  = D_stat;
      nx.icode = D_icode;
      nx.ifun  = D_ifun;
      nx.valC  = D_valC;
      nx.srcA  = src_a_of(D_icode, D_rA);
      nx.srcB  = src_b_of(D_icode, D_rB);
      nx.dstE  = dst_e_of(D_icode, D_rB);
      nx.dstM  = dst_m_of(D_icode, D_rA);
      nx.valA  = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : fwd_of(nx.srcA, rf_valA);
      nx.valB  = fwd_of(nx.srcB, rf_valB);
    end
    @(posedge clk);
    #1;
    exp_e = nx;
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic rand_inputs();
    D_stat = 2'($urandom); D_icode = 4'($urandom); D_ifun = 4'($urandom);
    D_rA = 4'($urandom); D_rB = 4'($urandom);
    D_valC = r64(); D_valP = r64(); rf_valA = r64(); rf_valB = r64();
    e_dstE = 4'($urandom); M_dstM = 4'($urandom); M_dstE = 4'($urandom);
    W_dstM = 4'($urandom); W_dstE = 4'($urandom);
    e_valE = r64(); m_valM = r64(); M_valE = r64(); W_valM = r64(); W_valE = r64();
    E_stall = 1'b0; E_bubble = 1'b0;
  endtask

  task automatic no_forwards();
    e_dstE = 4'hF; M_dstM = 4'hF; M_dstE = 4'hF; W_dstM = 4'hF; W_dstE = 4'hF;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      rand_inputs();
      E_stall = 1'($urandom); E_bubble = 1'($urandom);
      tick();
    end
    n_checks++;
    if ({E_icode, E_dstE, E_dstM, E_valA, load_use} !== {4'd1, 4'hF, 4'hF, 64'd0, 1'b0})
      $display("FAIL reset: icode/dstE/dstM/valA/load_use got %h/%h/%h/%h/%b required 1/f/f/0/0",
               E_icode, E_dstE, E_dstM, E_valA, load_use);
    else n_pass++;
    n_checks++;
    if (dut_e() !== bubble_e()) $display("FAIL reset_all: got %h required %h", dut_e(), bubble_e());
    else n_pass++;
    n_checks++;
    if (w_E_dstE !== 5'd31 || w_E_icode !== 4'd1)
      $display("FAIL reset_w: dstE %0d icode %0d required 31 1", w_E_dstE, w_E_icode);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    rand_inputs();
    D_icode = 4'h6; D_rA = 4'd3; D_rB = 4'd7;
    e_dstE = 4'd3; e_valE = 64'h11;
    M_dstM = 4'hF; M_dstE = 4'd3; M_valE = 64'h22;
    W_dstM = 4'hF; W_dstE = 4'd3; W_valE = 64'h33;
    tick();
    n_checks++;
    if (E_valA !== 64'h11) $display("FAIL prio_e: E_valA got %h required 11", E_valA);
    else n_pass++;
    e_dstE = 4'hF;
    tick();
    n_checks++;
    if (E_valA !== 64'h22) $display("FAIL prio_m: E_valA got %h required 22", E_valA);
    else n_pass++;
    M_dstM = 4'd3; m_valM = 64'h44;
    tick();
    n_checks++;
    if (E_valA !== 64'h44) $display("FAIL prio_mload: E_valA got %h required 44", E_valA);
    else n_pass++;
    n_checks++;
    if (dut_e() !== exp_e) $display("FAIL prio_all: got %h required %h", dut_e(), exp_e);
    else n_pass++;
  endtask

  task automatic test_call();
    rand_inputs();
    no_forwards();
    D_icode = 4'h8; D_valP = 64'h40; e_valE = 64'h99;
    tick();
    n_checks++;
    if ({E_valA, E_dstE, E_srcB} !== {64'h40, 4'd4, 4'd4})
      $display("FAIL call: valA/dstE/srcB got %h/%h/%h required 40/4/4", E_valA, E_dstE, E_srcB);
    else n_pass++;
  endtask

  task automatic test_load_use();
    rand_inputs();
    D_icode = 4'h5; D_rA = 4'd2; D_rB = 4'd7;
    tick();
    D_icode = 4'h6; D_rA = 4'd2; D_rB = 4'd6;
    #1;
    n_checks++;
    if (load_use !== 1'b1) $display("FAIL load_use_hit: got %b required 1", load_use);
    else n_pass++;
    D_rA = 4'd5;
    #1;
    n_checks++;
    if (load_use !== 1'b0) $display("FAIL load_use_miss: got %b required 0", load_use);
    else n_pass++;
  endtask

  task automatic test_control();
    e_t snap;
    rand_inputs();
    D_icode = 4'h6;
    tick();
    snap = exp_e;
    repeat (2) begin
      rand_inputs();
      E_stall = 1'b1;
      tick();
    end
    n_checks++;
    if (dut_e() !== snap) $display("FAIL stall_hold: got %h required %h", dut_e(), snap);
    else n_pass++;
    E_stall = 1'b1; E_bubble = 1'b1;
    tick();
    n_checks++;
    if (dut_e() !== bubble_e()) $display("FAIL stall_bubble: got %h required %h", dut_e(), bubble_e());
    else n_pass++;
  endtask

  task automatic test_async_reset();
    rand_inputs();
    D_icode = 4'h2;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    exp_e = bubble_e();
    n_checks++;
    if (dut_e() !== bubble_e()) $display("FAIL async_reset: got %h required %h", dut_e(), bubble_e());
    else n_pass++;
    #1;
    rst_n = 1'b1;
    rand_inputs();
    tick();
    n_checks++;
    if (dut_e() !== exp_e) $display("FAIL post_reset_load: got %h required %h", dut_e(), exp_e);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      if ($urandom_range(0, 2) == 0) e_dstE = D_rA;
      if ($urandom_range(0, 2) == 0) M_dstE = D_rB;
      if ($urandom_range(0, 3) == 0) W_dstM = D_rA;
      if ($urandom_range(0, 3) == 0) M_dstM = 4'd4;
      E_stall  = ($urandom_range(0, 7) == 0);
      E_bubble = ($urandom_range(0, 9) == 0);
      #1;
      n_checks++;
      if ({d_srcA, d_srcB, load_use} !== {src_a_of(D_icode, D_rA), src_b_of(D_icode, D_rB), exp_load_use()})
        $display("FAIL rand_comb[%0d]: srcA/srcB/lu got %h/%h/%b required %h/%h/%b", i,
                 d_srcA, d_srcB, load_use, src_a_of(D_icode, D_rA), src_b_of(D_icode, D_rB), exp_load_use());
      else n_pass++;
      tick();
      n_checks++;
      if (dut_e() !== exp_e) $display("FAIL rand_e[%0d]: got %h required %h", i, dut_e(), exp_e);
      else n_pass++;
    end
  endtask

  task automatic test_width();
    w_D_stat = 2'd1; w_D_icode = 4'h6; w_D_ifun = 4'd0;
    w_D_rA = 5'd31; w_D_rB = 5'd31;
    w_D_valC = 32'h8000_0001; w_D_valP = 32'h1234;
    w_rf_valA = 32'hA5A5_0001; w_rf_valB = 32'h5A5A_0002;
    w_e_dstE = 5'd31; w_M_dstM = 5'd31; w_M_dstE = 5'd31; w_W_dstM = 5'd31; w_W_dstE = 5'd31;
    w_e_valE = 32'h1; w_m_valM = 32'h2; w_M_valE = 32'h3; w_W_valM = 32'h4; w_W_valE = 32'h5;
    w_E_stall = 1'b0; w_E_bubble = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({w_E_valA, w_E_valB, w_E_valC, w_E_srcA} !== {32'hA5A5_0001, 32'h5A5A_0002, 32'h8000_0001, 5'd31})
      $display("FAIL width_rnone: valA/valB/valC/srcA got %h/%h/%h/%0d required a5a50001/5a5a0002/80000001/31",
               w_E_valA, w_E_valB, w_E_valC, w_E_srcA);
    else n_pass++;
    w_D_rA = 5'd17; w_e_dstE = 5'd17; w_e_valE = 32'hCAFE_0017;
    @(posedge clk);
    #1;
    n_checks++;
    if ({w_E_valA, w_E_srcA, w_E_dstE} !== {32'hCAFE_0017, 5'd17, 5'd31})
      $display("FAIL width_fwd: valA/srcA/dstE got %h/%0d/%0d required cafe0017/17/31",
               w_E_valA, w_E_srcA, w_E_dstE);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    exp_e = bubble_e();
    rand_inputs();
    w_D_stat = '0; w_D_icode = '0; w_D_ifun = '0; w_D_rA = '1; w_D_rB = '1;
    w_D_valC = '0; w_D_valP = '0; w_rf_valA = '0; w_rf_valB = '0;
    w_e_dstE = '1; w_M_dstM = '1; w_M_dstE = '1; w_W_dstM = '1; w_W_dstE = '1;
    w_e_valE = '0; w_m_valM = '0; w_M_valE = '0; w_W_valM = '0; w_W_valE = '0;
    w_E_stall = 1'b0; w_E_bubble = 1'b0;
    #1;
    test_reset();
    test_priority();
    test_call();
    test_load_use();
    test_control();
    test_async_reset();
    test_random();
    test_width();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
